hilo_unit: RTL and testbench
============================

# hilo_unit

Multiply/divide unit with the HI/LO register pair for the MIPS CPU, placed directly downstream of the main decoder. It consumes the 5-bit `alucontrol` codes for MULT/MULTU/DIV/DIVU/MTHI/MTLO together with the rs/rt operands. It performs multiplies in one cycle and divides iteratively over 32 cycles. It raises `busy` so the datapath stalls any MFHI/MFLO or further HI/LO operation until results are final.

## Interface
- No parameters; operand width is fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_enable`  in  1  when low, every register holds, including the divider iteration state.
- `start`  in  1  issue request; sampled on a rising edge with `clk_enable=1`.
- `op`  in  5  operation code, using the shared `alucontrol` encoding: MULTU=5'b00111, MULT=5'b01000, DIV=5'b01111, DIVU=5'b10000, MTHI=5'b10001, MTLO=5'b10010.
- `a`  in  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- `b`  in  32  rt value: multiplier or divisor.
- `busy`  out  1  high while a divide is in progress.
- `hi`  out  32  HI register, driven directly from the register (no added logic).
- `lo`  out  32  LO register, driven directly from the register (no added logic).

## Operation
- Two states: IDLE and DIV.
- Accept condition: `start & clk_enable & state==IDLE` and `op` is one of the six codes above. Any other `op`, or any `start` while in DIV, is ignored with no state change. The CPU is responsible for holding `start`.
- MULTU: {hi,lo} <= unsigned 64-bit a*b on the accept edge.
- MULT: {hi,lo} <= signed 64-bit a*b on the accept edge.
- MTHI: hi <= a on the accept edge; lo unchanged.
- MTLO: lo <= a on the accept edge; hi unchanged.
- DIV/DIVU on the accept edge:
  - Latch |a| and |b| for signed, or a and b raw for unsigned.
  - Latch the quotient-sign flag (operand signs differ, DIV only) and the remainder-sign flag (a negative, DIV only).
  - Clear the partial remainder, set iteration counter to 31, state -> DIV.
- DIV state, each enabled edge, one restoring step:
  - Shift {rem, quo} left by 1.
  - If rem >= divisor: rem -= divisor and set quo[0].
  - Decrement the counter.
- On the step where counter==0:
  - lo <= quotient, negated if the quotient-sign flag is set.
  - hi <= remainder, negated if the remainder-sign flag is set.
  - state -> IDLE.
- Divide by zero completes normally (32 steps), giving hi = a and lo = 0xFFFFFFFF for both DIV and DIVU. Both values are decided results, not X.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 and hi = 0.
- hi/lo keep their old values throughout a divide and change only on the final step.

## Timing
- Reset: on the first edge with `reset=1`, state=IDLE, busy=0, hi=0, lo=0, counter=0. Reset has priority over `clk_enable` and aborts an in-flight divide with no hi/lo update.
- MULT/MULTU/MTHI/MTLO: results are visible on hi/lo in the cycle after the accept edge. `busy` stays 0.
- DIV/DIVU:
  - `busy` = (state==DIV). It rises in the cycle after the accept edge and stays high for exactly 32 enabled cycles.
  - hi/lo are valid in the first cycle with busy=0 after the accept edge.
  - Total latency is 32 enabled edges.
- `clk_enable` low stretches all of the above cycle-for-cycle. `busy` stays high while frozen in DIV.
- A new op may be accepted in the same cycle `busy` falls, i.e. back-to-back with no bubble.

## Structure
- Shared package `mips_pkg`: localparams for the `alucontrol` codes above, shared with the controller's ALU decoder.
- Sub-module `div_core`: 32-bit unsigned restoring divider with load/step/done and remainder/quotient outputs. `hilo_unit` owns sign handling, the multiplier, the HI/LO registers and the FSM.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> next cycle hi=0xFFFFFFFE, lo=0x00000001, busy never high.
- MULT a=0xFFFFFFFE (-2) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7) b=2:
  - busy high for exactly 32 cycles; hi/lo unchanged until it falls.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> after 32 busy cycles hi=100, lo=0xFFFFFFFF. Then DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 issued during busy is ignored, and the final hi is the remainder. MTLO a=0x55 issued in the cycle busy falls is accepted: next cycle lo=0x55.
- Mid-operation disturbances:
  - Reset asserted at busy cycle 10 -> next cycle busy=0, hi=lo=0.
  - `clk_enable` held low for 5 cycles mid-divide -> busy lasts 37 cycles with a correct result.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: alucontrol codes used by the controller's ALU decoder
// and by the HI/LO unit, plus the HI/LO state type and a small sign helper.
package mips_pkg;

  localparam int unsigned XLen = 32;

  localparam logic [4:0] AluMultu = 5'b00111;
  localparam logic [4:0] AluMult  = 5'b01000;
  localparam logic [4:0] AluDiv   = 5'b01111;
  localparam logic [4:0] AluDivu  = 5'b10000;
  localparam logic [4:0] AluMthi  = 5'b10001;
  localparam logic [4:0] AluMtlo  = 5'b10010;

  typedef enum logic {
    StIdle,
    StDiv
  } hilo_state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [XLen-1:0] neg_if(input logic neg, input logic [XLen-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// 32-bit unsigned restoring divider: one quotient bit per step, 32 steps per divide.
// The quotient/remainder outputs are the values produced by the step currently being taken.
module div_core
  import mips_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLen-1:0] i_dividend,
  input  logic [XLen-1:0] i_divisor,
  output logic            o_last,
  output logic [XLen-1:0] o_quotient,
  output logic [XLen-1:0] o_remainder
);

  logic [XLen-1:0] r_rem;
  logic [XLen-1:0] r_quo;
  logic [XLen-1:0] r_dvsr;
  logic [4:0]      r_count;

  logic [XLen:0]   w_rem_sh;
  logic [XLen:0]   w_diff;
  logic            w_ge;
  logic [XLen-1:0] w_rem_nxt;
  logic [XLen-1:0] w_quo_nxt;

  // A zero divisor always subtracts nothing, so the quotient fills with ones and
  // the remainder ends up holding the dividend.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[XLen-1]};
    w_diff    = w_rem_sh - {1'b0, r_dvsr};
    w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
    w_quo_nxt = {r_quo[XLen-2:0], w_ge};
    w_rem_nxt = w_ge ? w_diff[XLen-1:0] : w_rem_sh[XLen-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_rem   <= '0;
      r_quo   <= i_dividend;
      r_dvsr  <= i_divisor;
      r_count <= 5'd31;
    end else if (i_step) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_count <= r_count - 5'd1;
    end
  end

  assign o_last      = (r_count == 5'd0);
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

endmodule

// File: rtl/hilo_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO and a 32-step iterative
// DIV/DIVU with sign fix-up; busy stalls the datapath while a divide runs.
module hilo_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enable,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLen-1:0] a,
  input  logic [XLen-1:0] b,
  output logic            busy,
  output logic [XLen-1:0] hi,
  output logic [XLen-1:0] lo
);

  hilo_state_e     r_state;
  logic [XLen-1:0] r_hi;
  logic [XLen-1:0] r_lo;
  logic            r_qneg;
  logic            r_rneg;

  logic            w_op_valid;
  logic            w_op_div;
  logic            w_op_signed;
  logic            w_accept;
  logic            w_load;
  logic            w_step;
  logic [XLen-1:0] w_a_abs;
  logic [XLen-1:0] w_b_abs;
  logic [63:0]     w_prod_u;
  logic [63:0]     w_prod_s;
  logic            w_div_last;
  logic [XLen-1:0] w_quo;
  logic [XLen-1:0] w_rem;

  always_comb begin
    w_op_valid  = 1'b0;
    w_op_div    = 1'b0;
    w_op_signed = 1'b0;
    case (op)
      AluMultu, AluMult, AluMthi, AluMtlo: w_op_valid = 1'b1;
      AluDiv: begin
        w_op_valid  = 1'b1;
        w_op_div    = 1'b1;
        w_op_signed = 1'b1;
      end
      AluDivu: begin
        w_op_valid = 1'b1;
        w_op_div   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_accept = start & clk_enable & (r_state == StIdle) & w_op_valid;
  assign w_load   = w_accept & w_op_div;
  assign w_step   = clk_enable & (r_state == StDiv);

  assign w_a_abs  = neg_if(w_op_signed & a[XLen-1], a);
  assign w_b_abs  = neg_if(w_op_signed & b[XLen-1], b);

  // Low 64 bits of the extended product equal the signed/unsigned 32x32 result.
  assign w_prod_u = {32'd0, a} * {32'd0, b};
  assign w_prod_s = {{32{a[XLen-1]}}, a} * {{32{b[XLen-1]}}, b};

  div_core u_div_core (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_dividend  (w_a_abs),
    .i_divisor   (w_b_abs),
    .o_last      (w_div_last),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_hi    <= '0;
      r_lo    <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else if (clk_enable) begin
      unique case (r_state)
        StIdle: begin
          if (start && w_op_valid) begin
            case (op)
              AluMultu: {r_hi, r_lo} <= w_prod_u;
              AluMult:  {r_hi, r_lo} <= w_prod_s;
              AluMthi:  r_hi <= a;
              AluMtlo:  r_lo <= a;
              AluDiv, AluDivu: begin
                r_state <= StDiv;
                // Divide by zero keeps the all-ones quotient regardless of signs.
                r_qneg  <= w_op_signed & (a[XLen-1] ^ b[XLen-1]) & (b != '0);
                r_rneg  <= w_op_signed & a[XLen-1];
              end
              default: ;
            endcase
          end
        end
        StDiv: begin
          if (w_div_last) begin
            r_lo    <= neg_if(r_qneg, w_quo);
            r_hi    <= neg_if(r_rneg, w_rem);
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == StDiv);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus pushes expected HI/LO results, a negedge
// monitor detects each result presentation and compares against the queue head.
module tb_hilo_unit;

  localparam logic [4:0] OpMultu = 5'b00111;
  localparam logic [4:0] OpMult  = 5'b01000;
  localparam logic [4:0] OpDiv   = 5'b01111;
  localparam logic [4:0] OpDivu  = 5'b10000;
  localparam logic [4:0] OpMthi  = 5'b10001;
  localparam logic [4:0] OpMtlo  = 5'b10010;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned blen;
    bit          is_div;
    logic [31:0] phi;
    logic [31:0] plo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  bit          pend     = 0;
  int unsigned pend_len = 0;
  bit          in_div   = 0;
  int unsigned busy_cnt = 0;
  bit          unstable = 0;

  hilo_unit dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic bit tb_valid(input logic [4:0] o);
    return o inside {OpMultu, OpMult, OpDiv, OpDivu, OpMthi, OpMtlo};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, expv);
    end
  endtask

  task automatic score(input int unsigned blen);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output: got hi=%h lo=%h, required no output", hi, lo);
      return;
    end
    e = q.pop_front();
    cmp({e.name, "_hi"}, hi, e.hi);
    cmp({e.name, "_lo"}, lo, e.lo);
    cmp({e.name, "_busy_len"}, blen, e.blen);
    cmp({e.name, "_busy_now"}, {31'd0, busy}, 32'd0);
    if (e.is_div) cmp({e.name, "_hilo_changed_during_busy"}, {31'd0, unstable}, 32'd0);
  endtask

  // Monitor: results appear one cycle after a quick accept or reset, or when busy falls.
  always @(negedge clk) begin
    if (pend) begin
      pend = 0;
      score(pend_len);
    end
    if (in_div) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (q.size() > 0 && (hi !== q[0].phi || lo !== q[0].plo)) unstable = 1;
      end else begin
        in_div = 0;
        score(busy_cnt);
      end
    end
    if (reset === 1'b1) begin
      pend     = 1;
      pend_len = in_div ? busy_cnt : 0;
      in_div   = 0;
    end else if (start && clk_enable && busy === 1'b0 && tb_valid(op)) begin
      if (op == OpDiv || op == OpDivu) begin
        in_div   = 1;
        busy_cnt = 0;
        unstable = 0;
      end else begin
        pend     = 1;
        pend_len = 0;
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] eh, input logic [31:0] el,
                      input int unsigned blen, input bit is_div);
    exp_t e;
    e.name   = nm;
    e.hi     = eh;
    e.lo     = el;
    e.blen   = blen;
    e.is_div = is_div;
    e.phi    = m_hi;
    e.plo    = m_lo;
    q.push_back(e);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after 100 cycles, required 0", busy);
    end
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b1;
    start      = 1'b0;
    op         = '0;
    a          = '0;
    b          = '0;
    m_hi       = '0;
    m_lo       = '0;

    push("reset", 32'h0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    push("multu", 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
    issue(OpMult, 32'hFFFF_FFFE, 32'd3);
    push("mthi", 32'hDEAD_BEEF, 32'hFFFF_FFFA, 0, 0);
    issue(OpMthi, 32'hDEAD_BEEF, 32'd0);
    push("mtlo", 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0);
    issue(OpMtlo, 32'h0BAD_F00D, 32'd0);

    // -7/2 with an MTHI during busy (ignored) and an MTLO held into the falling cycle
    push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 1);
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = OpMthi;
    a     = 32'h0000_1234;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    push("mtlo_b2b", 32'hFFFF_FFFF, 32'h0000_0055, 0, 0);
    start = 1'b1;
    op    = OpMtlo;
    a     = 32'h0000_0055;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;

    push("divu_by0", 32'd100, 32'hFFFF_FFFF, 32, 1);
    issue(OpDivu, 32'd100, 32'd0);
    wait_idle();
    push("div_ovf", 32'h0, 32'h8000_0000, 32, 1);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    push("div_100_m7", 32'd2, 32'hFFFF_FFF2, 32, 1);
    issue(OpDiv, 32'd100, 32'hFFFF_FFF9);
    wait_idle();
    push("divu_big", 32'h0000_000F, 32'h0FFF_FFFF, 32, 1);
    issue(OpDivu, 32'hFFFF_FFFF, 32'h10);
    wait_idle();

    issue(5'b00000, 32'h1111, 32'h2222);
    push("mtlo_after_bad_op", 32'h0000_000F, 32'h0000_0077, 0, 0);
    issue(OpMtlo, 32'h77, 32'd0);

    push("divu_ce_gap", 32'd6, 32'd142, 37, 1);
    issue(OpDivu, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1 clk_enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 clk_enable = 1'b1;
    wait_idle();

    push("div_abort", 32'h0, 32'h0, 10, 1);
    issue(OpDiv, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d results outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
